// File: rtl/execute_cycle_ext_if.sv
// E-stage operand/control bundle and EX/MEM register outputs of the execute stage.
// The master side feeds E-stage values and consumes M outputs; the slave side is the stage itself.
interface execute_cycle_ext_if #(
    parameter int XLEN = 32,
    parameter int REGW = 5
);
    logic            valid_e;
    logic [XLEN-1:0] RD1_E;
    logic [XLEN-1:0] RD2_E;
    logic [XLEN-1:0] Imm_Ext_E;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] PCPlus4E;
    logic [REGW-1:0] RD_E;
    logic            RegWriteE;
    logic            MemWriteE;
    logic            ALUSrcE;
    logic            BranchE;
    logic            JumpE;
    logic            MulE;
    logic [1:0]      ResultSrcE;
    logic [3:0]      ALUControlE;
    logic [2:0]      BranchF3E;
    logic            MulHiE;
    logic [1:0]      ForwardAE;
    logic [1:0]      ForwardBE;
    logic [XLEN-1:0] ResultW;
    logic            FlushE;

    logic [XLEN-1:0] ALUResultM;
    logic [XLEN-1:0] WriteDataM;
    logic [XLEN-1:0] PCPlus4M;
    logic [REGW-1:0] RD_M;
    logic            RegWriteM;
    logic            MemWriteM;
    logic            valid_m;
    logic [1:0]      ResultSrcM;
    logic [XLEN-1:0] PCTargetE;
    logic            PCSrcE;
    logic            stall_e;

    modport master (
        output valid_e, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E,
               RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, MulE,
               ResultSrcE, ALUControlE, BranchF3E, MulHiE,
               ForwardAE, ForwardBE, ResultW, FlushE,
        input  ALUResultM, WriteDataM, PCPlus4M, RD_M, RegWriteM, MemWriteM,
               valid_m, ResultSrcM, PCTargetE, PCSrcE, stall_e
    );

    modport slave (
        input  valid_e, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E,
               RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, MulE,
               ResultSrcE, ALUControlE, BranchF3E, MulHiE,
               ForwardAE, ForwardBE, ResultW, FlushE,
        output ALUResultM, WriteDataM, PCPlus4M, RD_M, RegWriteM, MemWriteM,
               valid_m, ResultSrcM, PCTargetE, PCSrcE, stall_e
    );
endinterface

// File: rtl/execute_cycle_ext.sv
// RISC-V execute stage: forwarding, ALU, branch/jump resolution, iterative shift-add
// multiplier (MUL/MULHU) that stalls the front end, and the EX/MEM pipeline register.
module execute_cycle_ext #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input logic                clk,
    input logic                rst,
    execute_cycle_ext_if.slave bus
);
    localparam int SHW = $clog2(XLEN);
    localparam int PW  = 2 * XLEN;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    mul_state_t state_q;
    mul_state_t state_d;

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_res;
    logic            br_cond;
    logic            mul_req;
    logic            mul_start;
    logic            cnt_last;
    logic            stall;
    logic            bubble;
    logic [XLEN-1:0] product;

    logic [XLEN-1:0] op_a_p1;
    logic [XLEN-1:0] op_b_p1;
    logic            hi_p1;
    logic [PW-1:0]   acc_p1;
    logic [SHW-1:0]  cnt_p1;

    logic [XLEN-1:0] alu_result_p2;
    logic [XLEN-1:0] write_data_p2;
    logic [XLEN-1:0] pc_plus4_p2;
    logic [REGW-1:0] rd_p2;
    logic            reg_write_p2;
    logic            mem_write_p2;
    logic            vld_p2;
    logic [1:0]      result_src_p2;

    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] rf_val,
        input logic [XLEN-1:0] wb_val,
        input logic [XLEN-1:0] mem_val
    );
        case (sel)
            2'b01:   return wb_val;
            2'b10:   return mem_val;
            default: return rf_val;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] alu_op(
        input logic [3:0]      ctl,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        logic [SHW-1:0]         shamt;
        sa    = a;
        sb    = b;
        shamt = b[SHW-1:0];
        case (ctl)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return {{(XLEN-1){1'b0}}, (sa < sb)};
            4'd6:    return {{(XLEN-1){1'b0}}, (a < b)};
            4'd7:    return a << shamt;
            4'd8:    return a >> shamt;
            4'd9:    return XLEN'(sa >>> shamt);
            default: return '0;
        endcase
    endfunction

    function automatic logic branch_taken(
        input logic [2:0]      f3,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        sa = a;
        sb = b;
        case (f3)
            3'b000:  return (a == b);
            3'b001:  return (a != b);
            3'b100:  return (sa < sb);
            3'b101:  return (sa >= sb);
            3'b110:  return (a < b);
            3'b111:  return (a >= b);
            default: return 1'b0;
        endcase
    endfunction

    // ---- stage p0: operand selection, ALU, branch resolution ----
    assign src_a   = fwd_sel(bus.ForwardAE, bus.RD1_E, bus.ResultW, alu_result_p2);
    assign fwd_b   = fwd_sel(bus.ForwardBE, bus.RD2_E, bus.ResultW, alu_result_p2);
    assign src_b   = bus.ALUSrcE ? bus.Imm_Ext_E : fwd_b;
    assign alu_res = alu_op(bus.ALUControlE, src_a, src_b);
    assign br_cond = branch_taken(bus.BranchF3E, src_a, fwd_b);

    assign bus.PCTargetE = bus.PCE + bus.Imm_Ext_E;
    assign bus.PCSrcE    = bus.valid_e & ~bus.FlushE & ~stall & ~rst &
                           ((bus.BranchE & br_cond) | bus.JumpE);

    // rst is folded in so the stall request drops the instant reset is asserted
    assign mul_req   = bus.valid_e & bus.MulE & ~bus.FlushE & ~rst;
    assign mul_start = (state_q == IDLE) & mul_req;
    assign cnt_last  = (cnt_p1 == SHW'(XLEN - 1));
    assign product   = hi_p1 ? acc_p1[PW-1:XLEN] : acc_p1[XLEN-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mul_req) begin
                    state_d = BUSY;
                    stall   = 1'b1;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (bus.FlushE) begin
                    state_d = IDLE;
                end else if (cnt_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.stall_e = stall;

    // ---- stage p1: multiplier operand latches and shift-add accumulator ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a_p1 <= '0;
            op_b_p1 <= '0;
            hi_p1   <= 1'b0;
            acc_p1  <= '0;
            cnt_p1  <= '0;
        end else if (mul_start) begin
            op_a_p1 <= src_a;
            op_b_p1 <= fwd_b;
            hi_p1   <= bus.MulHiE;
            acc_p1  <= '0;
            cnt_p1  <= '0;
        end else if (state_q == BUSY) begin
            if (op_b_p1[cnt_p1]) begin
                acc_p1 <= acc_p1 + ({{XLEN{1'b0}}, op_a_p1} << cnt_p1);
            end
            cnt_p1 <= cnt_p1 + SHW'(1);
        end
    end

    // ---- stage p2: EX/MEM register ----
    assign bubble = bus.FlushE | ~bus.valid_e | stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_result_p2 <= '0;
            write_data_p2 <= '0;
            pc_plus4_p2   <= '0;
            rd_p2         <= '0;
            result_src_p2 <= '0;
            reg_write_p2  <= 1'b0;
            mem_write_p2  <= 1'b0;
            vld_p2        <= 1'b0;
        end else if (bubble) begin
            reg_write_p2 <= 1'b0;
            mem_write_p2 <= 1'b0;
            vld_p2       <= 1'b0;
        end else begin
            // In DONE the forwarding paths may have moved on; use the latched operand
            alu_result_p2 <= (state_q == DONE) ? product : alu_res;
            write_data_p2 <= (state_q == DONE) ? op_b_p1 : fwd_b;
            pc_plus4_p2   <= bus.PCPlus4E;
            rd_p2         <= bus.RD_E;
            result_src_p2 <= bus.ResultSrcE;
            reg_write_p2  <= bus.RegWriteE;
            mem_write_p2  <= bus.MemWriteE;
            vld_p2        <= 1'b1;
        end
    end

    assign bus.ALUResultM = alu_result_p2;
    assign bus.WriteDataM = write_data_p2;
    assign bus.PCPlus4M   = pc_plus4_p2;
    assign bus.RD_M       = rd_p2;
    assign bus.ResultSrcM = result_src_p2;
    assign bus.RegWriteM  = reg_write_p2;
    assign bus.MemWriteM  = mem_write_p2;
    assign bus.valid_m    = vld_p2;
endmodule

// File: tb/tb_execute_cycle_ext.sv
// Directed and randomized bench for execute_cycle_ext against an arithmetic reference model.
module tb_execute_cycle_ext;
    localparam int XLEN = 32;
    localparam int REGW = 5;

    logic clk = 1'b0;
    logic rst;
    int   errors;
    int   checks;
    logic [31:0] m_alu;

    always #5 clk = ~clk;

    execute_cycle_ext_if #(.XLEN(XLEN), .REGW(REGW)) bus ();

    execute_cycle_ext #(.XLEN(XLEN), .REGW(REGW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        #200000;
        $display("FAIL global_timeout reached without finishing");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0]  sh;
        logic [31:0] pw;
        logic [31:0] ones;
        sh   = b[4:0];
        pw   = 32'd1 << sh;
        ones = 32'hFFFF_FFFF;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'd6:    return (a < b) ? 32'd1 : 32'd0;
            4'd7:    return a * pw;
            4'd8:    return a / pw;
            4'd9:    return (a / pw) | (a[31] ? ~(ones >> sh) : 32'd0);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_br(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic lt_s;
        lt_s = (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return lt_s;
            3'b101:  return !lt_s;
            3'b110:  return a < b;
            3'b111:  return !(a < b);
            default: return 1'b0;
        endcase
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        bus.valid_e     = 1'b0;
        bus.RD1_E       = '0;
        bus.RD2_E       = '0;
        bus.Imm_Ext_E   = '0;
        bus.PCE         = '0;
        bus.PCPlus4E    = '0;
        bus.RD_E        = '0;
        bus.RegWriteE   = 1'b0;
        bus.MemWriteE   = 1'b0;
        bus.ALUSrcE     = 1'b0;
        bus.BranchE     = 1'b0;
        bus.JumpE       = 1'b0;
        bus.MulE        = 1'b0;
        bus.ResultSrcE  = '0;
        bus.ALUControlE = '0;
        bus.BranchF3E   = '0;
        bus.MulHiE      = 1'b0;
        bus.ForwardAE   = '0;
        bus.ForwardBE   = '0;
        bus.ResultW     = '0;
        bus.FlushE      = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic use_imm, input logic [31:0] imm, input string tag);
        logic [31:0] exp;
        set_idle();
        bus.valid_e     = 1'b1;
        bus.ALUControlE = op;
        bus.RD1_E       = a;
        bus.RD2_E       = b;
        bus.ALUSrcE     = use_imm;
        bus.Imm_Ext_E   = imm;
        bus.RegWriteE   = 1'b1;
        exp = ref_alu(op, a, use_imm ? imm : b);
        tick();
        check32(tag, bus.ALUResultM, exp);
        m_alu = exp;
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic hi, input string tag);
        int          stalls;
        logic        bub_ok;
        logic [63:0] p;
        logic [31:0] exp;
        set_idle();
        bus.valid_e   = 1'b1;
        bus.MulE      = 1'b1;
        bus.MulHiE    = hi;
        bus.RD1_E     = a;
        bus.RD2_E     = b;
        bus.RegWriteE = 1'b1;
        bus.RD_E      = 5'd9;
        #1;
        stalls = 0;
        bub_ok = 1'b1;
        while (bus.stall_e === 1'b1 && stalls < 100) begin
            stalls++;
            tick();
            if (bus.valid_m !== 1'b0) bub_ok = 1'b0;
        end
        check32({tag, "_stall_cycles"}, stalls, XLEN + 1);
        check1({tag, "_bubbles"}, bub_ok, 1'b1);
        tick();
        set_idle();
        p   = 64'(a) * 64'(b);
        exp = hi ? p[63:32] : p[31:0];
        check32({tag, "_product"}, bus.ALUResultM, exp);
        check32({tag, "_wdata"}, bus.WriteDataM, b);
        check1({tag, "_valid"}, bus.valid_m, 1'b1);
        check32({tag, "_rd"}, 32'(bus.RD_M), 32'd9);
        m_alu = exp;
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b, imm, w, pce, sa, sb, exp;
        logic [1:0]  fa, fb;
        logic        use_imm;
        logic [2:0]  f3;
        errors = 0;
        checks = 0;
        m_alu  = '0;

        // reset with a live instruction presented
        rst = 1'b1;
        set_idle();
        bus.valid_e    = 1'b1;
        bus.RD1_E      = 32'h55;
        bus.RD2_E      = 32'h66;
        bus.RegWriteE  = 1'b1;
        bus.MemWriteE  = 1'b1;
        bus.RD_E       = 5'd4;
        bus.PCPlus4E   = 32'h10;
        bus.ResultSrcE = 2'b01;
        repeat (2) tick();
        check32("rst_alu", bus.ALUResultM, 32'd0);
        check32("rst_wdata", bus.WriteDataM, 32'd0);
        check32("rst_pc4", bus.PCPlus4M, 32'd0);
        check32("rst_rd", 32'(bus.RD_M), 32'd0);
        check32("rst_rsrc", 32'(bus.ResultSrcM), 32'd0);
        check1("rst_valid", bus.valid_m, 1'b0);
        check1("rst_regwrite", bus.RegWriteM, 1'b0);
        check1("rst_memwrite", bus.MemWriteM, 1'b0);
        check1("rst_stall", bus.stall_e, 1'b0);
        rst = 1'b0;

        // add 5 + 7
        set_idle();
        bus.valid_e    = 1'b1;
        bus.RD1_E      = 32'd5;
        bus.RD2_E      = 32'd7;
        bus.RegWriteE  = 1'b1;
        bus.RD_E       = 5'd3;
        bus.PCPlus4E   = 32'h44;
        bus.ResultSrcE = 2'b10;
        #1;
        check1("add_valid_before_edge", bus.valid_m, 1'b0);
        tick();
        check32("add_result", bus.ALUResultM, 32'd12);
        check1("add_regwrite", bus.RegWriteM, 1'b1);
        check1("add_valid", bus.valid_m, 1'b1);
        check32("add_rd", 32'(bus.RD_M), 32'd3);
        check32("add_wdata", bus.WriteDataM, 32'd7);
        check32("add_pc4", bus.PCPlus4M, 32'h44);
        check32("add_rsrc", 32'(bus.ResultSrcM), 32'd2);
        m_alu = 32'd12;

        alu_op(4'd0, 32'd10, 32'd10, 1'b0, 32'd0, "add_20");

        // sub with SrcA forwarded from ALUResultM
        set_idle();
        bus.valid_e     = 1'b1;
        bus.ALUControlE = 4'd1;
        bus.ForwardAE   = 2'b10;
        bus.RD1_E       = 32'd999;
        bus.RD2_E       = 32'd3;
        tick();
        check32("sub_fwd_m", bus.ALUResultM, 32'd17);
        m_alu = 32'd17;

        alu_op(4'd9, 32'h8000_0000, 32'd0, 1'b1, 32'd4, "sra_by4");
        check32("sra_literal", bus.ALUResultM, 32'hF800_0000);
        alu_op(4'd6, 32'd1, 32'hFFFF_FFFF, 1'b0, 32'd0, "sltu");
        check32("sltu_literal", bus.ALUResultM, 32'd1);

        // branch compare uses FwdB even though ALUSrcE selects the immediate
        set_idle();
        bus.valid_e   = 1'b1;
        bus.BranchE   = 1'b1;
        bus.BranchF3E = 3'b100;
        bus.RD1_E     = 32'hFFFF_FFFF;
        bus.RD2_E     = 32'd1;
        bus.PCE       = 32'h100;
        bus.Imm_Ext_E = 32'h20;
        bus.ALUSrcE   = 1'b1;
        #1;
        check1("blt_taken", bus.PCSrcE, 1'b1);
        check32("blt_target", bus.PCTargetE, 32'h120);
        bus.BranchF3E = 3'b110;
        #1;
        check1("bltu_not_taken", bus.PCSrcE, 1'b0);
        bus.BranchE = 1'b0;
        bus.JumpE   = 1'b1;
        #1;
        check1("jump_taken", bus.PCSrcE, 1'b1);
        bus.FlushE = 1'b1;
        #1;
        check1("jump_flushed", bus.PCSrcE, 1'b0);
        set_idle();
        tick();

        run_mul(32'hFFFF_FFFF, 32'd2, 1'b0, "mul");
        check32("mul_literal", bus.ALUResultM, 32'hFFFF_FFFE);
        run_mul(32'hFFFF_FFFF, 32'd2, 1'b1, "mulhu");
        check32("mulhu_literal", bus.ALUResultM, 32'h0000_0001);

        // flush together with a multiply start
        set_idle();
        bus.valid_e = 1'b1;
        bus.MulE    = 1'b1;
        bus.RD1_E   = 32'd6;
        bus.RD2_E   = 32'd7;
        bus.FlushE  = 1'b1;
        #1;
        check1("flush_start_stall", bus.stall_e, 1'b0);
        tick();
        check1("flush_start_valid", bus.valid_m, 1'b0);
        set_idle();
        #1;
        check1("flush_start_idle", bus.stall_e, 1'b0);
        tick();

        // flush at BUSY count 10
        set_idle();
        bus.valid_e = 1'b1;
        bus.MulE    = 1'b1;
        bus.RD1_E   = 32'h1234;
        bus.RD2_E   = 32'h10;
        repeat (11) tick();
        bus.FlushE = 1'b1;
        #1;
        check1("flush_busy_stall", bus.stall_e, 1'b1);
        tick();
        check1("flush_busy_valid", bus.valid_m, 1'b0);
        set_idle();
        bus.valid_e = 1'b1;
        bus.RD1_E   = 32'd1;
        bus.RD2_E   = 32'd2;
        #1;
        check1("after_flush_stall", bus.stall_e, 1'b0);
        tick();
        check32("after_flush_add", bus.ALUResultM, 32'd3);
        check1("after_flush_valid", bus.valid_m, 1'b1);
        m_alu = 32'd3;

        // reset in the middle of a multiply
        set_idle();
        bus.valid_e = 1'b1;
        bus.MulE    = 1'b1;
        bus.RD1_E   = 32'd7;
        bus.RD2_E   = 32'd9;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        check1("rstbusy_stall", bus.stall_e, 1'b0);
        check32("rstbusy_alu", bus.ALUResultM, 32'd0);
        check1("rstbusy_valid", bus.valid_m, 1'b0);
        check1("rstbusy_regwrite", bus.RegWriteM, 1'b0);
        set_idle();
        tick();
        rst = 1'b0;
        repeat (40) tick();
        check32("no_stale_product", bus.ALUResultM, 32'd0);
        check1("no_stale_valid", bus.valid_m, 1'b0);
        run_mul(32'd3, 32'd4, 1'b0, "mul_3x4");
        check32("mul_3x4_literal", bus.ALUResultM, 32'd12);

        // randomized ALU ops with forwarding
        for (int i = 0; i < 40; i++) begin
            op      = 4'($urandom_range(0, 15));
            a       = $urandom;
            b       = $urandom;
            imm     = $urandom;
            w       = $urandom;
            fa      = 2'($urandom_range(0, 3));
            fb      = 2'($urandom_range(0, 3));
            use_imm = 1'($urandom_range(0, 1));
            set_idle();
            bus.valid_e     = 1'b1;
            bus.ALUControlE = op;
            bus.RD1_E       = a;
            bus.RD2_E       = b;
            bus.Imm_Ext_E   = imm;
            bus.ALUSrcE     = use_imm;
            bus.ResultW     = w;
            bus.ForwardAE   = fa;
            bus.ForwardBE   = fb;
            bus.MemWriteE   = 1'($urandom_range(0, 1));
            sa  = (fa == 2'b01) ? w : (fa == 2'b10) ? m_alu : a;
            sb  = (fb == 2'b01) ? w : (fb == 2'b10) ? m_alu : b;
            exp = ref_alu(op, sa, use_imm ? imm : sb);
            tick();
            check32("rnd_alu", bus.ALUResultM, exp);
            check32("rnd_wdata", bus.WriteDataM, sb);
            m_alu = exp;
        end

        // randomized branches
        for (int i = 0; i < 20; i++) begin
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            pce = $urandom;
            imm = $urandom;
            f3  = 3'($urandom_range(0, 7));
            set_idle();
            bus.valid_e   = 1'b1;
            bus.BranchE   = 1'b1;
            bus.BranchF3E = f3;
            bus.RD1_E     = a;
            bus.RD2_E     = b;
            bus.PCE       = pce;
            bus.Imm_Ext_E = imm;
            #1;
            check1("rnd_branch", bus.PCSrcE, ref_br(f3, a, b));
            check32("rnd_target", bus.PCTargetE, pce + imm);
            tick();
            m_alu = a + b;
        end

        for (int i = 0; i < 3; i++) begin
            run_mul($urandom, $urandom, 1'($urandom_range(0, 1)), "rnd_mul");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
